regfile_wport_arb: RTL

- Owns the single write port of the 32x32 register file.
- Shares the port between two writers:
  - the in-order pipeline writeback, which has fixed priority and is never stalled by this block;
  - a long-latency unit (mul/div, load refill) that uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a 32-bit pending-write scoreboard so decode can detect hazards against results still in flight from the long-latency unit.

---
 rtl/regfile_wport_arb.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_wport_arb.sv
// rtl/regfile_wport_arb.sv - register file write-port arbiter with result FIFO and pending scoreboard
// Pipeline writeback always wins the port; long-latency results queue and drain in free slots.
module regfile_wport_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_pipe_we,
  input  logic [4:0]  i_pipe_wn,
  input  logic [31:0] i_pipe_d,
  input  logic        i_lu_valid,
  input  logic [4:0]  i_lu_wn,
  input  logic [31:0] i_lu_d,
  output logic        o_lu_ready,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_wn,
  input  logic [4:0]  i_rna,
  input  logic [4:0]  i_rnb,
  input  logic [4:0]  i_rnw,
  output logic        o_busy_a,
  output logic        o_busy_b,
  output logic        o_busy_w,
  output logic        o_stall_req,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_wn,
  output logic [31:0] o_rf_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [SW-1:0] L_SMAX  = SW'(STARVE_MAX);

  logic [4:0]    r_fifo_wn [DEPTH];
  logic [31:0]   r_fifo_d  [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_pending;

  logic        w_pipe_real;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic [4:0]  w_head_wn;
  logic [31:0] w_head_d;

  assign w_pipe_real = i_pipe_we && (i_pipe_wn != 5'd0);
  assign w_empty     = (r_cnt == '0);
  assign w_pop       = !w_empty && !w_pipe_real;
  assign w_head_wn   = r_fifo_wn[r_rp];
  assign w_head_d    = r_fifo_d[r_rp];
  // Readiness is gated by clrn so nothing is accepted while reset is held.
  assign o_lu_ready  = clrn && (r_cnt < L_DEPTH);
  assign w_push      = i_lu_valid && o_lu_ready;

  assign o_busy_a    = r_pending[i_rna];
  assign o_busy_b    = r_pending[i_rnb];
  assign o_busy_w    = r_pending[i_rnw];
  assign o_stall_req = (r_starve == L_SMAX);

  always_comb begin
    o_rf_we = 1'b0;
    o_rf_wn = 5'd0;
    o_rf_d  = 32'd0;
    if (clrn) begin
      if (w_pipe_real) begin
        o_rf_we = 1'b1;
        o_rf_wn = i_pipe_wn;
        o_rf_d  = i_pipe_d;
      end else if (w_pop && (w_head_wn != 5'd0)) begin
        o_rf_we = 1'b1;
        o_rf_wn = w_head_wn;
        o_rf_d  = w_head_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wn[r_wp] <= i_lu_wn;
      r_fifo_d[r_wp]  <= i_lu_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                 r_starve <= '0;
    else if (w_empty || w_pop) r_starve <= '0;
    else if (r_starve != L_SMAX) r_starve <= r_starve + 1'b1;
  end

  // The set is written after the clear so a same-cycle issue to the retiring register keeps it busy.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pending <= 32'd0;
    end else begin
      if (w_pop) r_pending[w_head_wn] <= 1'b0;
      if (i_iss_valid && (i_iss_wn != 5'd0)) r_pending[i_iss_wn] <= 1'b1;
    end
  end

endmodule
